// File: rtl/fec_run_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fec_run_controller                                                         |
// | Run sequencer for parallel_sys1: resets the datapath, streams the          |
// | probability table, runs until a stop condition, then latches statistics.   |
// | Optional feature macro: FEC_CTRL_TIMEOUT_EN (RUN cycle limit, reason 3).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fec_run_controller #(
    parameter int MAX_ENTRIES  = 16,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_we,
    input  logic [$clog2(MAX_ENTRIES)-1:0] cfg_addr,
    input  logic [63:0]                    cfg_data,
    input  logic [$clog2(MAX_ENTRIES):0]   n_entries,
    input  logic                           start,
    input  logic                           abort,
    input  logic [63:0]                    target_bits,
    input  logic [63:0]                    target_frame_errors,
`ifdef FEC_CTRL_TIMEOUT_EN
    input  logic [63:0]                    timeout_cycles,
`endif
    input  logic [63:0]                    total_bits,
    input  logic [63:0]                    total_bit_errors_pre,
    input  logic [63:0]                    total_bit_errors_post,
    input  logic [63:0]                    total_frames,
    input  logic [63:0]                    total_frame_errors,
    output logic                           sys_rstn,
    output logic                           sys_en,
    output logic [31:0]                    probability_idx,
    output logic [63:0]                    probability_in,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     stop_reason,
    output logic [63:0]                    res_bits,
    output logic [63:0]                    res_bit_errors_pre,
    output logic [63:0]                    res_bit_errors_post,
    output logic [63:0]                    res_frames,
    output logic [63:0]                    res_frame_errors
);

    localparam int AW = $clog2(MAX_ENTRIES);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_RESET_SYS = 3'd1;
    localparam logic [2:0] c_ST_LOAD      = 3'd2;
    localparam logic [2:0] c_ST_PARK      = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;
    localparam logic [2:0] c_ST_DRAIN     = 3'd5;
    localparam logic [2:0] c_ST_DONE      = 3'd6;

    localparam logic [1:0] c_RSN_BITS   = 2'd0;
    localparam logic [1:0] c_RSN_FRAMES = 2'd1;
    localparam logic [1:0] c_RSN_ABORT  = 2'd2;
`ifdef FEC_CTRL_TIMEOUT_EN
    localparam logic [1:0] c_RSN_TIMEOUT = 2'd3;
`endif

    localparam logic [31:0] c_RST_LAST   = RST_CYCLES - 1;
    localparam logic [31:0] c_DRAIN_LAST = DRAIN_CYCLES - 1;
    localparam logic [AW:0] c_MAX_N      = MAX_ENTRIES[AW:0];
    localparam logic [31:0] c_IDX_IDLE   = 32'hFFFF_FFFF;

    logic [2:0]  r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [AW:0] r_n_load;
    logic [31:0] w_n_ext;
    logic [1:0]  r_reason, w_reason;
    logic        w_timeout, w_hit_bits, w_hit_frames;
    logic [63:0] r_table [MAX_ENTRIES];

    logic        r_sys_rstn, r_sys_en, r_busy, r_done;
    logic [31:0] r_idx;
    logic [63:0] r_prob_in;
    logic [1:0]  r_stop_reason;
    logic [63:0] r_res_bits, r_res_pre, r_res_post, r_res_frames, r_res_fe;

`ifdef FEC_CTRL_TIMEOUT_EN
    logic [63:0] r_run_cnt;
    assign w_timeout = (timeout_cycles != 64'd0) && (r_run_cnt == timeout_cycles - 64'd1);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_hit_bits   = (target_bits != 64'd0) && (total_bits >= target_bits);
    assign w_hit_frames = (target_frame_errors != 64'd0) && (total_frame_errors >= target_frame_errors);
    assign w_n_ext      = 32'(r_n_load);

    always_comb begin
        w_state_nxt = r_state;
        w_reason    = r_reason;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_RESET_SYS;
            c_ST_RESET_SYS: begin
                if (abort) begin
                    w_state_nxt = c_ST_DONE;
                    w_reason    = c_RSN_ABORT;
                end else if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = (r_n_load == '0) ? c_ST_PARK : c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = c_ST_DONE;
                    w_reason    = c_RSN_ABORT;
                end else if (r_cnt == w_n_ext - 32'd1) begin
                    w_state_nxt = c_ST_PARK;
                end
            end
            c_ST_PARK: w_state_nxt = c_ST_RUN;
            c_ST_RUN: begin
                // Stop priority: abort > timeout > bits > frame errors
                if (abort || w_timeout || w_hit_bits || w_hit_frames) w_state_nxt = c_ST_DRAIN;
                if (abort) w_reason = c_RSN_ABORT;
`ifdef FEC_CTRL_TIMEOUT_EN
                else if (w_timeout) w_reason = c_RSN_TIMEOUT;
`endif
                else if (w_hit_bits) w_reason = c_RSN_BITS;
                else if (w_hit_frames) w_reason = c_RSN_FRAMES;
            end
            c_ST_DRAIN: if (r_cnt == c_DRAIN_LAST) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default: w_state_nxt = c_ST_IDLE;
        endcase
        // Per-state cycle counter doubles as the load index
        w_cnt_nxt = (w_state_nxt != r_state) ? 32'd0 : r_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_ENTRIES; i++) r_table[i] <= '0;
        end else if (cfg_we && r_state == c_ST_IDLE) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_n_load      <= '0;
            r_reason      <= '0;
            r_sys_rstn    <= 1'b0;
            r_sys_en      <= 1'b0;
            r_idx         <= c_IDX_IDLE;
            r_prob_in     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_stop_reason <= '0;
            r_res_bits    <= '0;
            r_res_pre     <= '0;
            r_res_post    <= '0;
            r_res_frames  <= '0;
            r_res_fe      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_reason <= w_reason;
            if (r_state == c_ST_IDLE && start)
                r_n_load <= (n_entries > c_MAX_N) ? c_MAX_N : n_entries;
            // Outside a run the datapath reset keeps its last value so counters stay readable
            if (w_state_nxt == c_ST_RESET_SYS) r_sys_rstn <= 1'b0;
            else if (w_state_nxt != c_ST_IDLE) r_sys_rstn <= 1'b1;
            r_sys_en <= (w_state_nxt == c_ST_RUN);
            r_busy   <= (w_state_nxt != c_ST_IDLE);
            r_done   <= (w_state_nxt == c_ST_DONE);
            if (w_state_nxt == c_ST_LOAD) begin
                r_idx     <= w_cnt_nxt;
                r_prob_in <= r_table[w_cnt_nxt[AW-1:0]];
            end else begin
                r_idx     <= c_IDX_IDLE;
            end
            if (w_state_nxt == c_ST_DONE) begin
                r_stop_reason <= w_reason;
                r_res_bits    <= total_bits;
                r_res_pre     <= total_bit_errors_pre;
                r_res_post    <= total_bit_errors_post;
                r_res_frames  <= total_frames;
                r_res_fe      <= total_frame_errors;
            end
        end
    end

`ifdef FEC_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstn || r_state != c_ST_RUN) r_run_cnt <= '0;
        else                              r_run_cnt <= r_run_cnt + 64'd1;
    end
`endif

    assign sys_rstn            = r_sys_rstn;
    assign sys_en              = r_sys_en;
    assign probability_idx     = r_idx;
    assign probability_in      = r_prob_in;
    assign busy                = r_busy;
    assign done                = r_done;
    assign stop_reason         = r_stop_reason;
    assign res_bits            = r_res_bits;
    assign res_bit_errors_pre  = r_res_pre;
    assign res_bit_errors_post = r_res_post;
    assign res_frames          = r_res_frames;
    assign res_frame_errors    = r_res_fe;

endmodule
`default_nettype wire

// File: tb/tb_fec_run_controller.sv
`default_nettype none
// Testbench for fec_run_controller: table-driven runs against a counter model
// with a scoreboard of expected latched results.
module tb_fec_run_controller;
    localparam int R = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, cfg_we, start, abort;
    logic [3:0]  cfg_addr;
    logic [63:0] cfg_data;
    logic [4:0]  n_entries;
    logic [63:0] target_bits, target_frame_errors;
`ifdef FEC_CTRL_TIMEOUT_EN
    logic [63:0] timeout_cycles = 64'd0;
`endif
    logic [63:0] total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors;
    logic        sys_rstn, sys_en, busy, done;
    logic [31:0] probability_idx;
    logic [63:0] probability_in;
    logic [1:0]  stop_reason;
    logic [63:0] res_bits, res_bit_errors_pre, res_bit_errors_post, res_frames, res_frame_errors;

    fec_run_controller #(.MAX_ENTRIES(16), .RST_CYCLES(R), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .n_entries(n_entries), .start(start), .abort(abort),
        .target_bits(target_bits), .target_frame_errors(target_frame_errors),
`ifdef FEC_CTRL_TIMEOUT_EN
        .timeout_cycles(timeout_cycles),
`endif
        .total_bits(total_bits), .total_bit_errors_pre(total_bit_errors_pre),
        .total_bit_errors_post(total_bit_errors_post), .total_frames(total_frames),
        .total_frame_errors(total_frame_errors),
        .sys_rstn(sys_rstn), .sys_en(sys_en), .probability_idx(probability_idx),
        .probability_in(probability_in), .busy(busy), .done(done), .stop_reason(stop_reason),
        .res_bits(res_bits), .res_bit_errors_pre(res_bit_errors_pre),
        .res_bit_errors_post(res_bit_errors_post), .res_frames(res_frames),
        .res_frame_errors(res_frame_errors)
    );

    // Datapath model: registered counts plus the contribution of the current enabled cycle
    logic [63:0] m_bits = 0, m_pre = 0, m_post = 0, m_frames = 0, m_fe = 0;
    logic [63:0] bits_inc = 64'd64, fe_inc = 64'd0;
    always @(posedge clk) begin
        if (!sys_rstn) begin
            m_bits <= 0; m_pre <= 0; m_post <= 0; m_frames <= 0; m_fe <= 0;
        end else if (sys_en) begin
            m_bits <= m_bits + bits_inc; m_pre <= m_pre + 64'd2; m_post <= m_post + 64'd1;
            m_frames <= m_frames + 64'd1; m_fe <= m_fe + fe_inc;
        end
    end
    assign total_bits            = m_bits   + (sys_en ? bits_inc : 64'd0);
    assign total_bit_errors_pre  = m_pre    + (sys_en ? 64'd2 : 64'd0);
    assign total_bit_errors_post = m_post   + (sys_en ? 64'd1 : 64'd0);
    assign total_frames          = m_frames + (sys_en ? 64'd1 : 64'd0);
    assign total_frame_errors    = m_fe     + (sys_en ? fe_inc : 64'd0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] mirror [16];

    typedef struct {
        logic [1:0]  reason;
        logic [63:0] bits, pre, post, frames, fe;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int          n;
        logic [63:0] tb, tfe, binc, feinc;
        int          abort_k;
        logic        we;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic [1:0]  reason;
        int          frames;
        logic [63:0] bits, fe;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: done=1 with no run outstanding, required 0");
            end else begin : sb_pop
                exp_t e;
                e = sb_q.pop_front();
                chk("stop_reason", {62'd0, stop_reason}, {62'd0, e.reason});
                chk("res_bits", res_bits, e.bits);
                chk("res_bit_errors_pre", res_bit_errors_pre, e.pre);
                chk("res_bit_errors_post", res_bit_errors_post, e.post);
                chk("res_frames", res_frames, e.frames);
                chk("res_frame_errors", res_frame_errors, e.fe);
            end
        end
    end

    task automatic push_exp(input logic [1:0] rsn, input int frames, input logic [63:0] bits, input logic [63:0] fe);
        exp_t e;
        e.reason = rsn; e.bits = bits; e.pre = 64'(2 * frames); e.post = 64'(frames);
        e.frames = 64'(frames); e.fe = fe;
        sb_q.push_back(e);
    endtask

    task automatic wait_en();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sys_en) begin ok = 1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL wait_sys_en: sys_en=0 after 200 cycles, required 1");
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0, c, k, nl, first_en, last_en, done_at, done_cnt;
        nl = (v.n > 16) ? 16 : v.n;
        target_bits = v.tb; target_frame_errors = v.tfe; bits_inc = v.binc; fe_inc = v.feinc;
        push_exp(v.reason, v.frames, v.bits, v.fe);
        @(negedge clk);
        n_entries = 5'(v.n); start = 1'b1;
        if (v.we) begin cfg_we = 1'b1; cfg_addr = v.wa; cfg_data = v.wd; mirror[v.wa] = v.wd; end
        t0 = cyc;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        first_en = -1; last_en = -1; done_at = -1; done_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            c = cyc;
            k = c - (t0 + 1 + R);
            if (c == t0 + 1) chk("start_busy", {63'd0, busy}, 64'd1);
            if (k >= 0 && k < nl) begin
                chk("load_idx", {32'd0, probability_idx}, 64'(k));
                chk("load_data", probability_in, mirror[k]);
            end else if (k == nl) begin
                chk("park_idx", {32'd0, probability_idx}, 64'hFFFF_FFFF);
            end
            if (sys_en) begin
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (v.abort_k >= 0 && first_en >= 0 && c == first_en + v.abort_k) abort = 1'b1;
            if (done) begin done_cnt++; done_at = c; abort = 1'b0; end
            if (done_at >= 0 && c == done_at + 1) begin
                chk("idle_busy", {63'd0, busy}, 64'd0);
                break;
            end
            @(negedge clk);
        end
        if (done_at < 0) begin
            n_checks++; n_fail++;
            $display("FAIL run_timeout: no done within 600 cycles, required one done pulse");
            abort = 1'b0;
            sb_q.delete();
        end else begin
            chk("first_en_cycle", 64'(first_en - t0), 64'(2 + R + nl));
            chk("en_cycles", 64'(last_en - first_en + 1), 64'(v.frames));
            chk("done_latency", 64'(done_at - last_en), 64'(1 + D));
            chk("done_width", 64'(done_cnt), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        vec_t hv;
        int t0;
        bit seen;
        rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; n_entries = '0;
        start = 1'b0; abort = 1'b0; target_bits = '0; target_frame_errors = '0;
        for (int i = 0; i < 16; i++) mirror[i] = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_sys_rstn", {63'd0, sys_rstn}, 64'd0);
        chk("rst_sys_en", {63'd0, sys_en}, 64'd0);
        chk("rst_idx", {32'd0, probability_idx}, 64'hFFFF_FFFF);
        chk("rst_prob_in", probability_in, 64'd0);
        chk("rst_busy", {62'd0, busy, done}, 64'd0);
        chk("rst_stop_reason", {62'd0, stop_reason}, 64'd0);
        chk("rst_res_bits", res_bits | res_frames | res_frame_errors, 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 4'(i);
            cfg_data = (i == 0) ? 64'h028f5c28f5c28f60 :
                       (i == 1) ? 64'hc000000000000000 : {32'hA5A5_0000, 32'(i * 7)};
            mirror[i] = cfg_data;
        end
        @(negedge clk);
        cfg_we = 1'b0;

        //         n   tb      tfe    binc    feinc  abk we  wa    wd        rsn  fr  bits     fe
        vecs[0] = '{2,  64'd1000, 64'd0,  64'd64,  64'd0, -1, 1'b0, 4'd0, 64'd0,      2'd0, 16, 64'd1024, 64'd0};
        vecs[1] = '{0,  64'd0,    64'd5,  64'd64,  64'd1, -1, 1'b0, 4'd0, 64'd0,      2'd1, 5,  64'd320,  64'd5};
        vecs[2] = '{3,  64'd640,  64'd10, 64'd64,  64'd1, -1, 1'b0, 4'd0, 64'd0,      2'd0, 10, 64'd640,  64'd10};
        vecs[3] = '{20, 64'd192,  64'd0,  64'd64,  64'd0, -1, 1'b0, 4'd0, 64'd0,      2'd0, 3,  64'd192,  64'd0};
        vecs[4] = '{1,  64'd0,    64'd0,  64'd64,  64'd1, 3,  1'b1, 4'd0, 64'h1234,   2'd2, 4,  64'd256,  64'd4};
        vecs[5] = '{5,  64'd5000, 64'd3,  64'd100, 64'd1, -1, 1'b0, 4'd0, 64'd0,      2'd1, 3,  64'd300,  64'd3};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort on the third LOAD cycle
        target_bits = 64'd0; target_frame_errors = 64'd0;
        push_exp(2'd2, 0, 64'd0, 64'd0);
        @(negedge clk);
        n_entries = 5'd8; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (R + 2) @(negedge clk);
        chk("abl_idx_k2", {32'd0, probability_idx}, 64'd2);
        abort = 1'b1;
        @(negedge clk);
        chk("abl_idx_idle", {32'd0, probability_idx}, 64'hFFFF_FFFF);
        chk("abl_done", {63'd0, done}, 64'd1);
        abort = 1'b0;
        @(negedge clk);
        chk("abl_busy", {63'd0, busy}, 64'd0);

        // Writes and start while busy are ignored
        bits_inc = 64'd64; fe_inc = 64'd0;
        push_exp(2'd2, 2, 64'd128, 64'd0);
        @(negedge clk);
        n_entries = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_en();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 64'hDEAD_BEEF_DEAD_BEEF; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0; abort = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("ign_done_seen", {63'd0, seen}, 64'd1);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ign_no_restart", {63'd0, busy}, 64'd0);
        end
        hv = '{2, 64'd64, 64'd0, 64'd64, 64'd0, -1, 1'b0, 4'd0, 64'd0, 2'd0, 1, 64'd64, 64'd0};
        run_vec(hv);

        // rstn mid-run: back to IDLE, no done, table cleared
        target_bits = 64'd0; target_frame_errors = 64'd0;
        @(negedge clk);
        n_entries = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_en();
        rstn = 1'b0;
        @(negedge clk);
        chk("rstn_busy", {63'd0, busy}, 64'd0);
        chk("rstn_sys_en", {63'd0, sys_en}, 64'd0);
        chk("rstn_sys_rstn", {63'd0, sys_rstn}, 64'd0);
        chk("rstn_idx", {32'd0, probability_idx}, 64'hFFFF_FFFF);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) mirror[i] = 64'd0;
        repeat (20) @(negedge clk);
        hv = '{2, 64'd64, 64'd0, 64'd64, 64'd0, -1, 1'b0, 4'd0, 64'd0, 2'd0, 1, 64'd64, 64'd0};
        run_vec(hv);

`ifdef FEC_CTRL_TIMEOUT_EN
        timeout_cycles = 64'd100;
        hv = '{0, 64'd0, 64'd0, 64'd64, 64'd0, -1, 1'b0, 4'd0, 64'd0, 2'd3, 100, 64'd6400, 64'd0};
        run_vec(hv);
        timeout_cycles = 64'd0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fec_run_controller.md
# fec_run_controller

Run sequencer for the `parallel_sys1` FEC error-rate datapath. It holds a host-written table of channel probability entries and drives the system reset. It streams the table into the datapath through the `probability_idx`/`probability_in` write port, then enables the run. It stops the run on a bit-count, frame-error, abort or timeout condition and latches the final statistics counters for readout.

## Interface
- `MAX_ENTRIES`, 16: probability table depth (power of two).
- `RST_CYCLES`, 4: cycles `sys_rstn` is held low before loading.
- `DRAIN_CYCLES`, 8: cycles after `sys_en` falls before statistics are latched.
- `clk` in 1: system clock, the same clock as `parallel_sys1`.
- `rstn` in 1: synchronous, active-low reset.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in log2(MAX_ENTRIES): table write address.
- `cfg_data` in 64: probability entry.
- `n_entries` in log2(MAX_ENTRIES)+1: number of entries to load; values above MAX_ENTRIES are clamped.
- `start` in 1: one-cycle run request.
- `abort` in 1: level; ends RESET_SYS, LOAD or RUN.
- `target_bits` in 64: stop when `total_bits` ≥ this value; 0 disables the check.
- `target_frame_errors` in 64: stop when `total_frame_errors` ≥ this value; 0 disables the check.
- `timeout_cycles` in 64: RUN cycle limit; port exists only with FEC_CTRL_TIMEOUT_EN.
- `total_bits`, `total_bit_errors_pre`, `total_bit_errors_post`, `total_frames`, `total_frame_errors` in 64 each: live datapath counters.
- `sys_rstn` out 1: datapath reset.
- `sys_en` out 1: datapath enable.
- `probability_idx` out 32: datapath table index; 32'hFFFFFFFF means idle.
- `probability_in` out 64: datapath table data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on run completion.
- `stop_reason` out 2: 0 = bits target, 1 = frame-error target, 2 = abort, 3 = timeout.
- `res_bits`, `res_bit_errors_pre`, `res_bit_errors_post`, `res_frames`, `res_frame_errors` out 64 each: latched results.

## Operation
- FSM states: IDLE → RESET_SYS → LOAD → PARK → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - `cfg_we` writes the table; writes outside IDLE are ignored.
  - `start` is sampled only in IDLE.
  - If `cfg_we` and `start` occur in the same cycle, the write is committed and is included in the load.
- RESET_SYS: `sys_rstn`=0, `sys_en`=0, `probability_idx`=FFFFFFFF for RST_CYCLES cycles.
- LOAD:
  - `sys_rstn`=1.
  - On consecutive cycles, drive `probability_idx`=k and `probability_in`=table[k] for k = 0 … n_entries−1.
  - If n_entries = 0, LOAD is skipped.
- PARK: one cycle with `probability_idx`=FFFFFFFF.
- RUN: `sys_en`=1. Stop conditions are evaluated every cycle, with priority abort > timeout > bits > frame errors.
- DRAIN: `sys_en`=0 for DRAIN_CYCLES cycles; `sys_rstn` stays 1.
- DONE:
  - Latch all five `res_*` registers from the live counters and `stop_reason`.
  - Pulse `done`.
  - Hold `sys_rstn` at 1 so the live counters remain readable until the next start.
- `abort` during RESET_SYS or LOAD:
  - Go directly to DONE with `stop_reason`=2 and `probability_idx` forced to FFFFFFFF.
  - `res_*` latch whatever the counters hold.
- If both targets are 0 and no timeout is compiled in, RUN ends only on `abort`.
- Comparisons are unsigned 64-bit. There is no counter wrap handling; the counters are treated as monotonic.
- The table contents survive runs and are cleared only by `rstn`.

## Timing
- Reset values:
  - state = IDLE.
  - `sys_rstn`=0, `sys_en`=0, `probability_idx`=FFFFFFFF, `probability_in`=0.
  - `busy`=0, `done`=0, `stop_reason`=0.
  - `res_*`=0, table = 0.
- All outputs are registered.
- `start` sampled in cycle T:
  - `busy`=1 and `sys_rstn`=0 from T+1.
  - LOAD begins at T+1+RST_CYCLES.
  - The first `sys_en`=1 occurs at T+2+RST_CYCLES+n_entries.
- A stop condition seen in RUN cycle S:
  - `sys_en`=0 from S+1.
  - DONE (`done`=1, `res_*` valid) at S+1+DRAIN_CYCLES.
  - IDLE (`busy`=0) at S+2+DRAIN_CYCLES.
- `rstn` low in any state returns to IDLE on the next edge and no `done` is issued.

## Configuration
- FEC_CTRL_TIMEOUT_EN defined:
  - Adds the `timeout_cycles` port and a 64-bit RUN cycle counter, cleared on RUN entry.
  - The run stops with `stop_reason`=3 when the counter equals `timeout_cycles` − 1; a value of 0 disables the timeout.
- Not defined: the port, the counter and stop reason 3 are absent.

## Test plan
- Table load:
  - Stimulus: write entry 0 = 028f5c28f5c28f60 and entry 1 = c000000000000000, n_entries=2, then start.
  - Response: `probability_idx` reads 0, then 1, then FFFFFFFF on consecutive cycles, with matching data, beginning RST_CYCLES+1 cycles after start.
- Bits stop:
  - Stimulus: target_bits=1000, target_frame_errors=0, model counter +64 per cycle.
  - Response: stop after the counter reaches 1024; `stop_reason`=0, `res_bits`=1024 (frozen during drain), `done` pulse width 1.
- Frame-error priority:
  - Stimulus: both targets are reached in the same cycle.
  - Response: `stop_reason`=0 (bits has priority).
- Abort during LOAD:
  - Stimulus: n_entries=8, assert abort on the 3rd load cycle.
  - Response: `probability_idx`=FFFFFFFF next cycle, DONE follows, `stop_reason`=2.
- Ignore rules:
  - Stimulus: `start` and `cfg_we` while `busy`.
  - Response: table unchanged and no restart; a subsequent start reloads the original table.
- Timeout (macro defined):
  - Stimulus: timeout_cycles=100, both targets 0.
  - Response: exactly 100 cycles of `sys_en`=1, `stop_reason`=3.
